// File: rtl/inv_sub_bytes_iter.sv
`default_nettype none
//==============================================================================
// inv_sub_bytes_iter : iterative AES InvSubBytes, LANES S-boxes shared over 16/LANES cycles.
// Optional macro INV_SUB_BYTES_COUNT_EN adds the blk_count output.   Rev 1.0
//==============================================================================
module inv_sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] x,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] z
`ifdef INV_SUB_BYTES_COUNT_EN
   ,
   output logic [15:0]  blk_count
`endif
);

   localparam int STEPS = 16 / LANES;
   localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [IDXW-1:0] c_last_idx = IDXW'(STEPS - 1);

   // Entry 0 sits in the most significant byte.
   localparam logic [2047:0] c_inv_sbox = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return c_inv_sbox[2047 - 8*int'(a) -: 8];
   endfunction

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state, w_state_next;
   logic [IDXW-1:0] r_idx;
   logic [127:0]    r_work;
   logic [127:0]    r_z;
   logic [127:0]    w_work_next;
   logic [7:0]      w_lane_in  [LANES];
   logic [7:0]      w_lane_out [LANES];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_lane_in[k]  = r_work[(int'(r_idx)*LANES + k)*8 +: 8];
      assign w_lane_out[k] = inv_sbox(w_lane_in[k]);
   end

   always_comb begin
      w_work_next = r_work;
      for (int k = 0; k < LANES; k++) begin
         w_work_next[(int'(r_idx)*LANES + k)*8 +: 8] = w_lane_out[k];
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = S_BUSY;
         end
         S_BUSY: begin
            if (r_idx == c_last_idx) w_state_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_work  <= '0;
         r_z     <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_work <= x;
                  r_idx  <= '0;
               end
            end
            S_BUSY: begin
               r_work <= w_work_next;
               // Output register only moves on the final step so z stays put otherwise.
               if (r_idx == c_last_idx) begin
                  r_idx <= '0;
                  r_z   <= w_work_next;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign z = r_z;

`ifdef INV_SUB_BYTES_COUNT_EN
   logic [15:0] r_blk_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_blk_count <= '0;
      else if (out_valid && out_ready) r_blk_count <= r_blk_count + 16'd1;
   end

   assign blk_count = r_blk_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_iter.sv
`default_nettype none
//==============================================================================
// tb_inv_sub_bytes_iter : scoreboard bench for inv_sub_bytes_iter against a GF(2^8) model.
// Rev 1.0
//==============================================================================
module tb_inv_sub_bytes_iter;

   localparam int LANES = 4;
   localparam int STEPS = 16 / LANES;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] x;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] z;
`ifdef INV_SUB_BYTES_COUNT_EN
   logic [15:0]  blk_count;
`endif

   inv_sub_bytes_iter #(.LANES(LANES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z)
`ifdef INV_SUB_BYTES_COUNT_EN
      ,
      .blk_count (blk_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] z;
      int           acc;
   } exp_t;

   exp_t        sbq[$];
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
   logic        prev_ov = 1'b0;
   logic [15:0] model_cnt = '0;
   logic [7:0]  inv_tab [256];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0)      out_ready = 1'b0;
      else if (rdy_mode == 1) out_ready = 1'b1;
      else                    out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: forward S-box from GF(2^8) inversion plus affine map, then inverted as a permutation.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_model();
      for (int v = 0; v < 256; v++) begin
         logic [7:0] bv = 8'(v);
         logic [7:0] iv = 8'h00;
         logic [7:0] s;
         if (v != 0) begin
            for (int y = 1; y < 256; y++) begin
               if (gmul(bv, 8'(y)) == 8'h01) iv = 8'(y);
            end
         end
         s = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
         inv_tab[s] = bv;
      end
   endtask

   function automatic logic [127:0] model(input logic [127:0] xv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[xv[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive one block; expected result is queued when the accept is seen.
   task automatic send(input logic [127:0] xv, input logic [127:0] expv);
      int t = 0;
      exp_t e;
      in_valid = 1'b1;
      x        = xv;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 200);
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 (cycle %0d)", cyc);
      end else begin
         e.z   = expv;
         e.acc = cyc + 1;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x        = rnd128();
   endtask

   task automatic drain();
      int t = 0;
      while ((sbq.size() != 0 || out_valid) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      n_tests++;
      if (sbq.size() != 0 || out_valid) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every presented output against the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov   = 1'b0;
         model_cnt = '0;
      end else begin
         if (out_valid) begin
            if (sbq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_output: got z=%h expected no output", z);
            end else begin
               if (!prev_ov) chk("latency", 128'(cyc - sbq[0].acc), 128'(STEPS));
               chk("in_ready_done", 128'(in_ready), 128'd0);
               chk("z", z, sbq[0].z);
               if (out_ready) begin
`ifdef INV_SUB_BYTES_COUNT_EN
                  chk("blk_count", 128'(blk_count), 128'(model_cnt));
`endif
                  model_cnt = model_cnt + 16'd1;
                  void'(sbq.pop_front());
               end
            end
         end
         prev_ov = out_valid;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] xa;
      logic [127:0] xb;
      logic [127:0] xs;
      int           t;

      build_model();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      x        = '0;

      repeat (3) begin
         @(negedge clk);
         chk("rst_in_ready", 128'(in_ready), 128'd1);
         chk("rst_out_valid", 128'(out_valid), 128'd0);
         chk("rst_z", z, 128'd0);
`ifdef INV_SUB_BYTES_COUNT_EN
         chk("rst_blk_count", 128'(blk_count), 128'd0);
`endif
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("idle_in_ready", 128'(in_ready), 128'd1);
         chk("idle_out_valid", 128'(out_valid), 128'd0);
         chk("idle_z", z, 128'd0);
      end
      @(posedge clk);
      #1;

      // Known vectors with fixed expectations.
      send(128'h0f0e0d0c0b0a09080706050403020100, 128'hfbd7f3819ea340bf38a53630d56a0952);
      send({16{8'h63}}, 128'd0);
      send({16{8'h16}}, {16{8'hff}});
      drain();

      // Every byte value through every byte position (and hence every lane).
      for (int v = 0; v < 256; v++) begin
         for (int i = 0; i < 16; i++) xs[8*i +: 8] = 8'(v + i);
         send(xs, model(xs));
      end
      drain();

      // Random data with random downstream stalls and idle gaps.
      rdy_mode = 2;
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         xs = rnd128();
         send(xs, model(xs));
      end
      rdy_mode = 1;
      drain();

      // Backpressure: a new request must wait while the result is held.
      rdy_mode = 0;
      xa = rnd128();
      xb = rnd128();
      send(xa, model(xa));
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      x        = xb;
      repeat (10) begin
         @(negedge clk);
         chk("bp_in_ready", 128'(in_ready), 128'd0);
         chk("bp_z_held", z, model(xa));
      end
      rdy_mode = 1;
      send(xb, model(xb));
      drain();

      // Asynchronous reset in the middle of BUSY aborts the block.
      xa = rnd128();
      send(xa, model(xa));
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 128'(out_valid), 128'd0);
      chk("midrst_in_ready", 128'(in_ready), 128'd1);
      chk("midrst_z", z, 128'd0);
      sbq.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("post_rst_out_valid", 128'(out_valid), 128'd0);
      end
      @(posedge clk);
      #1;

      for (int n = 0; n < 5; n++) begin
         xs = rnd128();
         send(xs, model(xs));
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
- Iterative AES InvSubBytes unit for the decryption datapath. It applies the FIPS-197 inverse S-box to every byte of a 128-bit state.
- It uses LANES inverse S-box instances that are time-shared over 16/LANES cycles, trading latency for area relative to the fully parallel 16-instance forward SubBytes.
- It sits between InvShiftRows and AddRoundKey in the decryption round. Valid/ready handshakes on both sides.

Parameters:
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16 (must divide 16). Elaboration error otherwise.
- STEPS, 16/LANES, derived localparam, not overridable; number of BUSY cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  x is valid
- in_ready  output  1  block can accept x
- x  input  128  input state; byte i = x[8i+7:8i]
- out_valid  output  1  z is valid
- out_ready  input  1  downstream accepts z
- z  output  128  result; z byte i = InvSbox(x byte i)
- blk_count  output  16  completed blocks (present only with the optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, state register=0.
  - Outputs: in_ready=1, out_valid=0, z=0, blk_count=0.
- Reset asserted mid-operation aborts the block. No output is produced for it.
- Inverse S-box: full 256-entry constant combinational table per lane, exact FIPS-197 values. Lane k at step idx handles byte idx*LANES+k.
- FSM states:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On in_valid&in_ready: capture x into a 128-bit working register, idx<=0, go to BUSY.
  - BUSY:
    - in_ready=0.
    - Each cycle, overwrite bytes idx*LANES .. idx*LANES+LANES-1 of the working register with their inverse S-box values, then idx<=idx+1.
    - When idx==STEPS-1, the update happens and the FSM goes to DONE with idx<=0.
  - DONE:
    - out_valid=1, in_ready=0.
    - z is driven from the working register and is held stable while out_valid&!out_ready.
    - On out_ready: go to IDLE.
    - out_valid deasserts on the next edge; the earliest next accept is one cycle later.
- Latency: out_valid rises exactly STEPS rising edges after the accepting edge. LANES=4 gives 4; LANES=16 gives 1.
- Throughput: one block per STEPS+2 cycles with out_ready held high.
- in_valid outside IDLE is ignored. x is sampled only at the accepting edge; later changes to x have no effect.
- z holds its last value in IDLE and BUSY. Consumers qualify it with out_valid.
- idx width: clog2(STEPS), minimum 1 bit. The wrap from STEPS-1 to 0 is explicit, not modular overflow.

Optional Feature:
- Macro: INV_SUB_BYTES_COUNT_EN.
- Defined:
  - Adds output blk_count[15:0], reset to 0.
  - Increments by 1 on each out_valid&out_ready edge.
  - Wraps 0xFFFF -> 0x0000.
- Undefined:
  - Port and counter are absent.
  - Remaining behaviour is identical and cycle-exact.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n low, then high, with in_valid=0.
  - Required: in_ready=1, out_valid=0, z=0, blk_count=0 throughout.
- Known vector, LANES=4:
  - Stimulus: x=128'h0f0e0d0c0b0a09080706050403020100 accepted at edge T, out_ready=1.
  - Required: out_valid high after edge T+4, z=128'hfbd7f3819ea340bf38a53630d56a0952.
- Round trip:
  - Stimulus: x=128'h63636363636363636363636363636363.
  - Required: z=0.
  - Stimulus: x=all 0x16.
  - Required: z=all 0xff.
  - Also sweep all 256 byte values through each lane and compare against the forward SubBytes inverse relation, for LANES=1,4,16.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid, while in_valid=1 with a new x.
  - Required: z stable, in_ready=0, new x not accepted.
  - Then: out_ready=1 for one cycle → IDLE; new x accepted next cycle.
- Reset mid-op:
  - Stimulus: drop rst_n at BUSY step 2.
  - Required: immediately out_valid=0, in_ready=1, z=0; no spurious output after release.
- Counter, macro defined:
  - Stimulus: preload blk_count to 0xFFFE by running 65534 blocks (or force), then complete 3 blocks.
  - Required: blk_count sequence 0xFFFF, 0x0000, 0x0001.
  - Macro undefined: port absent; behaviour unchanged.
